mesh_sort_sched: RTL and testbench

- Phase scheduler for the SQRT_N x SQRT_N sorting mesh that carries write requests ({valid, addr, data}) from the nodes to memory.
- Sequences a shearsort: load, then ROUNDS x (snake row phase + column phase), then a final ascending row phase, then a one-cycle memory write-back.
- Each sort phase is SORT_CYCLES odd-even transposition steps.
- The block drives the per-node compare-exchange enables; it contains no datapath.

---
 rtl/mesh_sort_sched_if.sv | 49 ++++
 rtl/mesh_sort_sched.sv | 182 ++++++++++++++++++
 tb/tb_mesh_sort_sched.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mesh_sort_sched_if.sv
// Control bundle between the shearsort phase scheduler and the sorting mesh.
// master = scheduler side, slave = mesh/memory side.
interface mesh_sort_sched_if #(
    parameter int STEP_W = 2,
    parameter int RND_W  = 1
);
    logic              start;
    logic              swap_any;
    logic              busy;
    logic              done;
    logic              load_en;
    logic              cmp_en;
    logic              cmp_odd;
    logic              cmp_col;
    logic              snake_en;
    logic              wb_en;
    logic [RND_W-1:0]  round;
    logic [STEP_W-1:0] step;

    modport master (
        input  start,
        input  swap_any,
        output busy,
        output done,
        output load_en,
        output cmp_en,
        output cmp_odd,
        output cmp_col,
        output snake_en,
        output wb_en,
        output round,
        output step
    );

    modport slave (
        output start,
        output swap_any,
        input  busy,
        input  done,
        input  load_en,
        input  cmp_en,
        input  cmp_odd,
        input  cmp_col,
        input  snake_en,
        input  wb_en,
        input  round,
        input  step
    );
endinterface

// File: rtl/mesh_sort_sched.sv
// Shearsort phase scheduler for the write-request sorting mesh.
// Optional early phase exit on two quiet steps: MESH_SORT_SCHED_EARLY_EXIT_EN.
module mesh_sort_sched #(
    parameter int N           = 4,
    parameter int SQRT_N      = 2,
    parameter int SORT_CYCLES = 4,
    parameter int ROUNDS      = 2,
    parameter int STEP_W      = 2,
    parameter int RND_W       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mesh_sort_sched_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROW,
        S_COL,
        S_FROW,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SORT_CYCLES - 1);
    localparam logic [RND_W-1:0]  RND_LAST  = RND_W'(ROUNDS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic [RND_W-1:0]  round_q;
    logic [RND_W-1:0]  round_d;
    logic              is_cmp_q;
    logic              is_cmp_d;
    logic              last_step;
    logic              early;
    logic              end_ph;

    logic              busy_q;
    logic              done_q;
    logic              load_q;
    logic              cmp_q;
    logic              odd_q;
    logic              col_q;
    logic              snake_q;
    logic              wb_q;

    logic              unused_cfg;
    assign unused_cfg = (N == SQRT_N * SQRT_N);

    assign is_cmp_q  = (state_q == S_ROW) || (state_q == S_COL) ||
                       (state_q == S_FROW);
    assign last_step = (step_q == STEP_LAST);

`ifdef MESH_SORT_SCHED_EARLY_EXIT_EN
    // Set when the previous compare step of this phase saw no swap.
    logic quiet_q;

    assign early = (step_q != '0) && quiet_q && !bus.swap_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            quiet_q <= 1'b0;
        end else begin
            quiet_q <= is_cmp_q && !end_ph && !bus.swap_any;
        end
    end
`else
    logic unused_swap;
    assign unused_swap = bus.swap_any;
    assign early       = 1'b0;
`endif

    assign end_ph = last_step || early;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        round_d = round_q;
        if (is_cmp_q) begin
            step_d = end_ph ? '0 : step_q + 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                step_d  = '0;
                round_d = '0;
                if (bus.start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_ROW;
                step_d  = '0;
                round_d = '0;
            end
            S_ROW: begin
                if (end_ph) begin
                    state_d = S_COL;
                end
            end
            S_COL: begin
                if (end_ph) begin
                    if (round_q == RND_LAST) begin
                        state_d = S_FROW;
                    end else begin
                        state_d = S_ROW;
                        round_d = round_q + 1'b1;
                    end
                end
            end
            S_FROW: begin
                if (end_ph) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                round_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
                round_d = '0;
            end
        endcase
    end

    assign is_cmp_d = (state_d == S_ROW) || (state_d == S_COL) ||
                      (state_d == S_FROW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            round_q <= round_d;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            cmp_q   <= 1'b0;
            odd_q   <= 1'b0;
            col_q   <= 1'b0;
            snake_q <= 1'b0;
            wb_q    <= 1'b0;
        end else begin
            busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q  <= (state_d == S_DONE);
            load_q  <= (state_d == S_LOAD);
            cmp_q   <= is_cmp_d;
            odd_q   <= is_cmp_d && step_d[0];
            col_q   <= (state_d == S_COL);
            snake_q <= (state_d == S_ROW);
            wb_q    <= (state_d == S_WRITE);
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.load_en  = load_q;
    assign bus.cmp_en   = cmp_q;
    assign bus.cmp_odd  = odd_q;
    assign bus.cmp_col  = col_q;
    assign bus.snake_en = snake_q;
    assign bus.wb_en    = wb_q;
    assign bus.round    = round_q;
    assign bus.step     = step_q;

endmodule

// File: tb/tb_mesh_sort_sched.sv
// Directed bench for mesh_sort_sched with a per-cycle expected-output queue.
// Early-exit expectations follow MESH_SORT_SCHED_EARLY_EXIT_EN.
module tb_mesh_sort_sched;

    localparam int SC = 4;
    localparam int RN = 2;
    localparam int SW = 2;
    localparam int RW = 1;
    localparam int NPH = 2 * RN + 1;

    typedef struct {
        logic [7:0]    fl;
        logic [SW-1:0] st;
        logic [RW-1:0] rd;
        bit            chk;
        int            mk;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mesh_sort_sched_if #(.STEP_W(SW), .RND_W(RW)) bus ();

    mesh_sort_sched #(
        .N(4),
        .SQRT_N(2),
        .SORT_CYCLES(SC),
        .ROUNDS(RN),
        .STEP_W(SW),
        .RND_W(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   mk         = 0;
    int   pl         = SC;
    int   plen       = SC;
    int   n_done_exp = 0;
    int   n_done_obs = 0;
    int   cyc_n      = 0;
    bit   post       = 1'b0;
    bit   sw_hold    = 1'b0;

    // Expected outputs for pass offset m (1 = LOAD) with phase length l.
    // fl = {busy, done, load_en, cmp_en, cmp_odd, cmp_col, snake_en, wb_en}
    function automatic exp_t expect_of(int m, int l, bit pp);
        exp_t e;
        int   p;
        int   s;
        e.fl  = '0;
        e.st  = '0;
        e.rd  = '0;
        e.chk = 1'b1;
        e.mk  = m;
        if (m == 0) begin
            e.chk = !pp;
        end else if (m == 1) begin
            e.fl = 8'b1010_0000;
        end else if (m <= 1 + NPH * l) begin
            p        = (m - 2) / l;
            s        = (m - 2) % l;
            e.fl[7]  = 1'b1;
            e.fl[4]  = 1'b1;
            e.fl[3]  = s[0];
            e.fl[2]  = (p % 2 == 1);
            e.fl[1]  = (p % 2 == 0) && (p < 2 * RN);
            e.st     = SW'(s);
            e.rd     = RW'((p / 2 < RN) ? p / 2 : RN - 1);
        end else if (m == 2 + NPH * l) begin
            e.fl  = 8'b1000_0001;
            e.chk = 1'b0;
        end else begin
            e.fl  = 8'b0100_0000;
            e.chk = 1'b0;
        end
        return e;
    endfunction

    task automatic cyc(input logic s, input logic r);
        exp_t       e;
        int         nm;
        logic [7:0] obs;
        rst       = r;
        bus.start = s;
`ifdef MESH_SORT_SCHED_EARLY_EXIT_EN
        bus.swap_any = sw_hold;
`else
        bus.swap_any = 1'($urandom);
`endif
        if (r) begin
            nm = 0;
        end else if (mk == 0) begin
            nm = s ? 1 : 0;
            if (s) pl = plen;
        end else if (mk == 3 + NPH * pl) begin
            nm = 0;
        end else begin
            nm = mk + 1;
        end
        if (r) post = 1'b0;
        else if (nm == 2 + NPH * pl) post = 1'b1;
        if (nm == 3 + NPH * pl) n_done_exp++;
        mk = nm;
        q.push_back(expect_of(nm, pl, post));

        @(posedge clk);
        #1;
        cyc_n++;
        e   = q.pop_front();
        obs = {bus.busy, bus.done, bus.load_en, bus.cmp_en,
               bus.cmp_odd, bus.cmp_col, bus.snake_en, bus.wb_en};
        if (bus.done === 1'b1) n_done_obs++;
        checks++;
        assert (obs === e.fl) else begin
            failures++;
            $error("FAIL flags cyc=%0d off=%0d got=%b exp=%b",
                   cyc_n, e.mk, obs, e.fl);
        end
        if (e.chk) begin
            checks++;
            assert ({bus.step, bus.round} === {e.st, e.rd}) else begin
                failures++;
                $error("FAIL cnt cyc=%0d off=%0d step/round got=%0d/%0d exp=%0d/%0d",
                       cyc_n, e.mk, bus.step, bus.round, e.st, e.rd);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.swap_any = 1'b0;
`ifdef MESH_SORT_SCHED_EARLY_EXIT_EN
        plen = 2;
`else
        plen = SC;
`endif

        // reset, then idle with start low
        repeat (2) cyc(1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b0);

        // single pass from a one-cycle start pulse
        cyc(1'b1, 1'b0);
        repeat (26) cyc(1'b0, 1'b0);

        // start held high: back-to-back passes
        repeat (50) cyc(1'b1, 1'b0);
        repeat (26) cyc(1'b0, 1'b0);

        // reset mid-pass, then a full pass
        cyc(1'b1, 1'b0);
        for (int j = 1; j <= 11; j++) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        repeat (26) cyc(1'b0, 1'b0);

        // start pulses while busy / in DONE are ignored
        cyc(1'b1, 1'b0);
        for (int j = 1; j <= 27; j++)
            cyc((j == 5) || (j == 15) || (j == 23), 1'b0);

`ifdef MESH_SORT_SCHED_EARLY_EXIT_EN
        // swaps every step: phases run full length
        sw_hold = 1'b1;
        plen    = SC;
        cyc(1'b1, 1'b0);
        repeat (26) cyc(1'b0, 1'b0);
        sw_hold = 1'b0;
        plen    = 2;
        cyc(1'b1, 1'b0);
        repeat (16) cyc(1'b0, 1'b0);
`endif

        checks++;
        assert (n_done_obs === n_done_exp) else begin
            failures++;
            $error("FAIL done_count got=%0d exp=%0d", n_done_obs, n_done_exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
